// File: rtl/div_clk_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_clk_monitor: measures high/low phases of a clk-derived divided clock,
// checks them against EXP_HALF and reports lock, mismatches and stalls.
// Rev 1.0
// ----------------------------------------------------------------------------
module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 2,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_HALF);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_N);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             have_high_q, have_high_d;
  logic             rise_pulse_q, rise_pulse_d;
  logic             fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;

  logic             edge_det, is_rise, is_fall, run_sat, phase_ok;
  logic [3:0]       good_inc;

  assign edge_det = s1_q ^ s2_q;
  assign is_rise  = edge_det & s1_q;
  assign is_fall  = edge_det & ~s1_q;
  assign run_sat  = (run_cnt_q == CNT_MAX);
  assign phase_ok = (run_cnt_q == EXP_VAL);
  assign good_inc = (good_cnt_q >= LOCK_VAL) ? LOCK_VAL : good_cnt_q + 4'd1;

  always_comb begin
    s1_d           = sig_in;
    s2_d           = s1_q;
    run_cnt_d      = edge_det ? CNT_W'(1) : (run_sat ? run_cnt_q : run_cnt_q + CNT_W'(1));
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    have_high_d    = have_high_q;
    rise_pulse_d   = is_rise;
    fall_pulse_d   = is_fall;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    err_d          = 1'b0;
    stall_d        = 1'b0;

    case (state_q)
      // The level seen first is only a partial phase: the edge ending it arms measurement.
      ST_INIT: begin
        if (edge_det) begin
          state_d     = ST_MEAS;
          good_cnt_d  = 4'd0;
          have_high_d = 1'b0;
        end
      end
      ST_MEAS, ST_LOCK: begin
        if (edge_det) begin
          if (is_fall) begin
            high_cnt_d  = run_cnt_q;
            have_high_d = 1'b1;
          end else begin
            low_cnt_d = run_cnt_q;
            if (have_high_q) begin
              period_d       = {1'b0, high_cnt_q} + {1'b0, run_cnt_q};
              period_valid_d = 1'b1;
            end
          end
          if (phase_ok) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_VAL) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end
          end else begin
            err_d      = 1'b1;
            good_cnt_d = 4'd0;
            locked_d   = 1'b0;
            state_d    = ST_MEAS;
          end
        end else if (run_sat) begin
          stall_d     = 1'b1;
          err_d       = 1'b1;
          locked_d    = 1'b0;
          good_cnt_d  = 4'd0;
          have_high_d = 1'b0;
          state_d     = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_INIT;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      run_cnt_q      <= '0;
      good_cnt_q     <= 4'd0;
      have_high_q    <= 1'b0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      run_cnt_q      <= run_cnt_d;
      good_cnt_q     <= good_cnt_d;
      have_high_q    <= have_high_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      stall_q        <= stall_d;
    end
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign high_cnt     = high_cnt_q;
  assign low_cnt      = low_cnt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign stall        = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_div_clk_monitor: phase-table stimulus with an event scoreboard for
// div_clk_monitor (CNT_W=8, EXP_HALF=2, LOCK_N=4).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_div_clk_monitor;

  localparam int SAT   = 255;
  localparam int NROWS = 28;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       sig_in = 1'b0;
  logic       rise_pulse, fall_pulse, period_valid, locked, err, stall;
  logic [7:0] high_cnt, low_cnt;
  logic [8:0] period;

  div_clk_monitor #(.CNT_W(8), .EXP_HALF(2), .LOCK_N(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .high_cnt     (high_cnt),
    .low_cnt      (low_cnt),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // One row = drive a new level, hold it, and the report expected for that edge.
  typedef struct {
    logic       rst_before;
    logic       lvl;
    int         hold;
    logic       stall_after;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [8:0] per;
    logic       pv;
    logic       lk;
    logic       er;
  } row_t;

  typedef struct {
    int          cyc;
    logic [30:0] v;
  } exp_t;

  row_t  tbl [NROWS];
  exp_t  sbq [$];
  int    total = 0;
  int    bad   = 0;
  logic  lk_track = 1'b0;

  function automatic logic [30:0] obs();
    return {rise_pulse, fall_pulse, high_cnt, low_cnt, period, period_valid, locked, err, stall};
  endfunction

  task automatic push_ev(input int c, input logic r, input logic f, input logic [7:0] hi,
                         input logic [7:0] lo, input logic [8:0] per, input logic pv,
                         input logic lk, input logic er, input logic st);
    exp_t e;
    e.cyc = c;
    e.v   = {r, f, hi, lo, per, pv, lk, er, st};
    sbq.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    logic [30:0] act;
    act = obs();
    total++;
    if (act !== 31'd0) begin
      bad++;
      $display("FAIL %s: outputs=%h required=0", nm, act);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset_mid_phase");
    reset = 1'b1;
  endtask

  task automatic monitor();
    logic [30:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      act = obs();
      if (rst_q !== 1'b1) begin
        lk_track = 1'b0;
      end else if ((rise_pulse | fall_pulse | period_valid | err | stall) === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, act);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || act !== e.v) begin
            bad++;
            $display("FAIL edge_report: cyc=%0d got=%h required cyc=%0d val=%h",
                     cyc, act, e.cyc, e.v);
          end
          lk_track = e.v[2];
        end
      end else begin
        total++;
        if (locked !== lk_track) begin
          bad++;
          $display("FAIL locked_level cyc=%0d got=%b required=%b", cyc, locked, lk_track);
        end
      end
    end
  endtask

  task automatic stimulus();
    // rst_before, lvl, hold, stall_after, hi, lo, per, pv, lk, err
    tbl[0]  = '{1'b0, 1'b1,   2, 1'b0, 8'd0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1,   3, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0,   2, 1'b0, 8'd3, 8'd2, 9'd4, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1,   2, 1'b0, 8'd3, 8'd2, 9'd5, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd5, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 300, 1'b1, 8'd2, 8'd2, 9'd4, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1,   1, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0,   2, 1'b0, 8'd1, 8'd2, 9'd4, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b1,   2, 1'b0, 8'd1, 8'd2, 9'd3, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd3, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0,   3, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b1,   2, 1'b0, 8'd0, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd0, 9'd0, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b1,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b1, 1'b1, 1'b0};
    tbl[27] = '{1'b0, 1'b0,   2, 1'b0, 8'd2, 8'd2, 9'd4, 1'b0, 1'b1, 1'b0};

    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b1;

    // sig_in held low from reset: counter saturates silently, nothing reported.
    repeat (300) @(posedge clk);
    #1;
    check_zero("const_zero");

    for (int i = 0; i < NROWS; i++) begin
      if (tbl[i].rst_before) do_reset();
      sig_in = tbl[i].lvl;
      push_ev(cyc + 2, tbl[i].lvl, ~tbl[i].lvl, tbl[i].hi, tbl[i].lo, tbl[i].per,
              tbl[i].pv, tbl[i].lk, tbl[i].er, 1'b0);
      if (tbl[i].stall_after)
        push_ev(cyc + 2 + SAT, 1'b0, 1'b0, tbl[i].hi, tbl[i].lo, tbl[i].per,
                1'b0, 1'b0, 1'b1, 1'b1);
      repeat (tbl[i].hold) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending_events=%0d required=0", sbq.size());
    end
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
